// File: rtl/pulse_meas_pkg.sv
// Shared types and defaults for the pulse width / period measurement block.
package pulse_meas_pkg;

   localparam int unsigned CNT_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      StIdle,
      StHigh,
      StLow
   } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with load-to-1; sat stays set from reaching max until the next load.
module sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         sat
);

   localparam logic [W-1:0] MaxVal = '1;
   localparam logic [W-1:0] One    = W'(1);

   logic [W-1:0] cnt_q;
   logic         sat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else if (load) begin
         cnt_q <= One;
         sat_q <= (One == MaxVal);
      end else if (en && (cnt_q != MaxVal)) begin
         cnt_q <= cnt_q + One;
         if ((cnt_q + One) == MaxVal) sat_q <= 1'b1;
      end
   end

   assign cnt = cnt_q;
   assign sat = sat_q;

endmodule

// File: rtl/pulse_meas.sv
// Measures high time and period between rising-edge pulses; results offered on a
// valid/ready interface with a sticky overrun flag.
module pulse_meas
   import pulse_meas_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pos_edge,
   input  logic             neg_edge,
   input  logic             res_ready,
   output logic             res_valid,
   output logic [CNT_W-1:0] high_width,
   output logic [CNT_W-1:0] period,
   output logic             sat,
   output logic             overrun,
   output logic             busy
);

   state_e state_q, state_d;

   logic             pos, neg;
   logic             cnt_load, hi_en, per_en, publish;
   logic [CNT_W-1:0] hi_cnt, per_cnt;
   logic             hi_sat, per_sat;

   logic             valid_q, sat_q, overrun_q;
   logic [CNT_W-1:0] hw_q, per_q;

   // Coincident edges carry no usable information and are dropped.
   assign pos = pos_edge & ~neg_edge;
   assign neg = neg_edge & ~pos_edge;

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      hi_en    = 1'b0;
      per_en   = 1'b0;
      publish  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pos) begin
               state_d  = StHigh;
               cnt_load = 1'b1;
            end
         end
         StHigh: begin
            if (pos) begin
               cnt_load = 1'b1;
            end else if (neg) begin
               state_d = StLow;
               per_en  = 1'b1;
            end else begin
               hi_en  = 1'b1;
               per_en = 1'b1;
            end
         end
         StLow: begin
            if (pos) begin
               state_d  = StHigh;
               cnt_load = 1'b1;
               publish  = 1'b1;
            end else begin
               per_en = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   sat_cnt #(
      .W (CNT_W)
   ) u_hi_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .en   (hi_en),
      .cnt  (hi_cnt),
      .sat  (hi_sat)
   );

   sat_cnt #(
      .W (CNT_W)
   ) u_per_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .en   (per_en),
      .cnt  (per_cnt),
      .sat  (per_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         hw_q      <= '0;
         per_q     <= '0;
         sat_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else if (publish) begin
         valid_q <= 1'b1;
         hw_q    <= hi_cnt;
         per_q   <= per_cnt;
         sat_q   <= hi_sat | per_sat;
         if (valid_q && !res_ready) overrun_q <= 1'b1;
      end else if (valid_q && res_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign res_valid  = valid_q;
   assign high_width = hw_q;
   assign period     = per_q;
   assign sat        = sat_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_pulse_meas.sv
// Self-checking bench: timestamp-based reference model drives expectations for a
// 16-bit and a 4-bit instance fed with identical stimulus.
module tb_pulse_meas;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pos_edge = 1'b0;
   logic neg_edge = 1'b0;
   logic res_ready = 1'b0;

   logic        v16, sat16, ov16, busy16;
   logic [15:0] hw16, per16;
   logic        v4, sat4, ov4, busy4;
   logic [3:0]  hw4, per4;

   int total = 0;
   int bad = 0;
   bit run = 1'b0;

   always #5 clk = ~clk;

   pulse_meas dut16 (
      .clk        (clk),
      .rst        (rst),
      .pos_edge   (pos_edge),
      .neg_edge   (neg_edge),
      .res_ready  (res_ready),
      .res_valid  (v16),
      .high_width (hw16),
      .period     (per16),
      .sat        (sat16),
      .overrun    (ov16),
      .busy       (busy16)
   );

   pulse_meas #(
      .CNT_W (4)
   ) dut4 (
      .clk        (clk),
      .rst        (rst),
      .pos_edge   (pos_edge),
      .neg_edge   (neg_edge),
      .res_ready  (res_ready),
      .res_valid  (v4),
      .high_width (hw4),
      .period     (per4),
      .sat        (sat4),
      .overrun    (ov4),
      .busy       (busy4)
   );

   // Reference model: measurement described by cycle timestamps, clamped per width.
   int mx [2] = '{65535, 15};
   int now = 0;
   bit active = 1'b0;
   bit got_neg = 1'b0;
   int t_pos = 0;
   int t_neg = 0;
   bit e_valid = 1'b0;
   bit e_ovr = 1'b0;
   int e_hw [2] = '{0, 0};
   int e_per [2] = '{0, 0};
   bit e_sat [2] = '{1'b0, 1'b0};

   function automatic int clampi(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit p, input bit n, input bit r, input bit rs);
      bit pv, nv, hs;
      int w, pd;
      pv = p && !n;
      nv = n && !p;
      hs = e_valid && r;
      if (rs) begin
         active  = 1'b0;
         got_neg = 1'b0;
         e_valid = 1'b0;
         e_ovr   = 1'b0;
         for (int k = 0; k < 2; k++) begin
            e_hw[k] = 0; e_per[k] = 0; e_sat[k] = 1'b0;
         end
      end else begin
         if (pv && active && got_neg) begin
            w  = t_neg - t_pos;
            pd = now - t_pos;
            for (int k = 0; k < 2; k++) begin
               e_hw[k]  = clampi(w, mx[k]);
               e_per[k] = clampi(pd, mx[k]);
               e_sat[k] = (w >= mx[k]) || (pd >= mx[k]);
            end
            if (e_valid && !r) e_ovr = 1'b1;
            e_valid = 1'b1;
         end else if (hs) begin
            e_valid = 1'b0;
         end
         if (pv) begin
            active  = 1'b1;
            got_neg = 1'b0;
            t_pos   = now;
         end else if (nv && active && !got_neg) begin
            got_neg = 1'b1;
            t_neg   = now;
         end
      end
      now++;
   endtask

   always @(negedge clk) begin
      if (run) begin
         check("res_valid16", 32'(v16), 32'(e_valid));
         check("high_width16", 32'(hw16), e_hw[0]);
         check("period16", 32'(per16), e_per[0]);
         check("sat16", 32'(sat16), 32'(e_sat[0]));
         check("overrun16", 32'(ov16), 32'(e_ovr));
         check("busy16", 32'(busy16), 32'(active));
         check("res_valid4", 32'(v4), 32'(e_valid));
         check("high_width4", 32'(hw4), e_hw[1]);
         check("period4", 32'(per4), e_per[1]);
         check("sat4", 32'(sat4), 32'(e_sat[1]));
         check("overrun4", 32'(ov4), 32'(e_ovr));
         check("busy4", 32'(busy4), 32'(active));
      end
   end

   task automatic cyc(input bit p, input bit n, input bit r, input bit rs);
      pos_edge  = p;
      neg_edge  = n;
      res_ready = r;
      rst       = rs;
      @(posedge clk);
      model_step(p, n, r, rs);
      #1;
   endtask

   task automatic idle(input int cnt, input bit r);
      for (int i = 0; i < cnt; i++) cyc(1'b0, 1'b0, r, 1'b0);
   endtask

   initial begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      run = 1'b1;
      check("reset_valid", 32'(v16), 32'd0);
      check("reset_busy", 32'(busy16), 32'd0);

      // Basic 3/10 measurement, result present for one cycle only.
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      idle(6, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      check("basic_valid", 32'(v16), 32'd1);
      check("basic_hw", 32'(hw16), 32'd3);
      check("basic_per", 32'(per16), 32'd10);
      check("basic_sat", 32'(sat16), 32'd0);
      idle(1, 1'b1);
      check("basic_valid_drop", 32'(v16), 32'd0);

      // Saturation: 20/30 fits in 16 bits, clamps to 15/15 in 4 bits.
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      idle(19, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      idle(9, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      check("sat4_hw", 32'(hw4), 32'd15);
      check("sat4_per", 32'(per4), 32'd15);
      check("sat4_flag", 32'(sat4), 32'd1);
      check("sat16_hw", 32'(hw16), 32'd20);
      check("sat16_per", 32'(per16), 32'd30);

      // Two unconsumed results: second overwrites and overrun sticks until reset.
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(6, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("ovr_hw", 32'(hw16), 32'd4);
      check("ovr_per", 32'(per16), 32'd8);
      check("ovr_valid", 32'(v16), 32'd1);
      check("ovr_flag", 32'(ov16), 32'd1);
      idle(3, 1'b1);
      check("ovr_sticky", 32'(ov16), 32'd1);
      check("ovr_consumed", 32'(v16), 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      check("ovr_cleared", 32'(ov16), 32'd0);

      // Missed neg: second pos restarts, single 2/7 result.
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      idle(4, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      idle(1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      idle(4, 1'b1);
      check("restart_no_result", 32'(v16), 32'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      check("restart_hw", 32'(hw16), 32'd2);
      check("restart_per", 32'(per16), 32'd7);

      // Coincident edges ignored.
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      idle(5, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      check("both_hw", 32'(hw16), 32'd3);
      check("both_per", 32'(per16), 32'd10);

      // Mid-measurement reset, then a fresh 2/6 measurement.
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(4, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      check("rst_busy", 32'(busy16), 32'd0);
      check("rst_hw", 32'(hw16), 32'd0);
      idle(14, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      idle(1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);
      check("rst_no_early", 32'(v16), 32'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      check("rst_valid", 32'(v16), 32'd1);
      check("rst_after_hw", 32'(hw16), 32'd2);
      check("rst_after_per", 32'(per16), 32'd6);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
      end

      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
